score_text_writer: RTL and testbench

Sequential character-buffer writer for the on-screen text overlay. Accepts a binary score (or a clear command), converts it to decimal with a multi-cycle double-dabble engine, and writes one glyph code per cycle into a small character buffer. Text renderers read the buffer combinationally per pixel and use each code as the glyph index into `alphabet_rom` (ROM address = code × 16 + row).

---
 rtl/score_text_pkg.sv | 25 ++
 rtl/score_text_writer_bin2bcd.sv | 83 ++++++++
 rtl/score_text_writer.sv | 220 ++++++++++++++++++++++
 tb/tb_score_text_writer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_text_pkg.sv
// Shared definitions for the score text writer.
//
// Contents:
//    CODE_BLANK   glyph code of an empty character cell
//    CODE_DIGIT0  glyph code of decimal digit 0; digits 1..9 follow contiguously
//    st_t         top-level sequencer states
//    digit_code   maps a BCD digit to its glyph code
package score_text_pkg;

   localparam logic [7:0] CODE_BLANK  = 8'h00;
   localparam logic [7:0] CODE_DIGIT0 = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONVERT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_CLEAR   = 3'd3,
      ST_DONE    = 3'd4
   } st_t;

   function automatic logic [7:0] digit_code(input logic [3:0] d);
      return CODE_DIGIT0 + {4'h0, d};
   endfunction

endpackage

// File: rtl/score_text_writer_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
//
// A start pulse loads the binary value; the engine then performs one
// add-3/shift step per cycle for exactly SCORE_W cycles. Any bit shifted out
// of the top BCD digit means the value does not fit in DIGITS decimal digits,
// which is reported on ovf_o.
//
// Ports:
//    clk_i    system clock
//    rst_ni   asynchronous active-low reset
//    start_i  load bin_i and begin converting (sampled on the clock edge)
//    bin_i    binary value to convert
//    busy_o   conversion in progress
//    done_o   high during the cycle whose edge performs the final shift
//    bcd_o    DIGITS packed BCD digits, least significant in bits [3:0]
//    ovf_o    value exceeded 10^DIGITS-1 (valid once busy_o drops)
module bin2bcd_seq #(
   parameter int SCORE_W = 16,
   parameter int DIGITS  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [SCORE_W-1:0]    bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DIGITS*4-1:0]   bcd_o,
   output logic                  ovf_o
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0] bin_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [BCD_W-1:0]   adj;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               ovf_q;

   // Add-3 correction: any digit of 5 or more would exceed 9 after doubling,
   // so bias it by 3 before the shift to produce the decimal carry.
   always_comb begin
      adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[k*4 +: 4] >= 4'd5) begin
            adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
         end
      end
   end

   // Shift register and step counter. Overflow is sticky for the whole
   // conversion because a lost carry can never be recovered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (start_i) begin
         bin_q  <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= CNT_W'(SCORE_W);
         busy_q <= 1'b1;
         ovf_q  <= 1'b0;
      end else if (busy_q) begin
         bcd_q <= {adj[BCD_W-2:0], bin_q[SCORE_W-1]};
         bin_q <= bin_q << 1;
         ovf_q <= ovf_q | adj[BCD_W-1];
         cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CNT_W'(1));
   assign bcd_o  = bcd_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/score_text_writer.sv
// score_text_writer: writes a decimal score (or a full clear) into a small
// character buffer, one glyph code per cycle, for the text overlay renderers.
//
// Build option:
//    SCORE_TEXT_LZ_BLANK_EN  when defined, leading zero digits are written as
//                            CODE_BLANK; the least significant digit is
//                            always a digit. Write cycle count is unchanged.
//
// Ports:
//    Clk        system clock
//    Reset_n    asynchronous active-low reset (buffer returns to all blank)
//    req_valid  request present
//    req_ready  idle; request accepted on req_valid && req_ready
//    req_clear  request blanks the whole buffer
//    req_score  value to display
//    req_base   slot receiving the most significant digit
//    busy       high in every state except idle
//    done       one-cycle pulse when a request completes
//    ovf        last score request exceeded 10^DIGITS-1 (all nines written)
//    rd_slot    renderer read address
//    rd_code    glyph code at rd_slot, combinational from the buffer
module score_text_writer
   import score_text_pkg::*;
#(
   parameter int SLOTS   = 8,
   parameter int DIGITS  = 5,
   parameter int SCORE_W = 16,
   parameter int CODE_W  = 8
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_clear,
   input  logic [SCORE_W-1:0]        req_score,
   input  logic [$clog2(SLOTS)-1:0]  req_base,
   output logic                      busy,
   output logic                      done,
   output logic                      ovf,
   input  logic [$clog2(SLOTS)-1:0]  rd_slot,
   output logic [CODE_W-1:0]         rd_code
);

   localparam int SLOT_W = $clog2(SLOTS);
   localparam logic [SLOT_W-1:0] LAST_DIG  = SLOT_W'(DIGITS - 1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   generate
      if (DIGITS > SLOTS) begin : g_bad_digits
         $error("score_text_writer: DIGITS must not exceed SLOTS");
      end
      if ((SLOTS < 2) || ((SLOTS & (SLOTS - 1)) != 0)) begin : g_bad_slots
         $error("score_text_writer: SLOTS must be a power of two, at least 2");
      end
   endgenerate

   st_t                 state_q, state_d;
   logic [SLOT_W-1:0]   idx_q, idx_d;
   logic [SLOT_W-1:0]   base_q, base_d;
   logic                ovf_q, ovf_d;
`ifdef SCORE_TEXT_LZ_BLANK_EN
   logic                lz_q, lz_d;
`endif

   logic [CODE_W-1:0]   buf_q [SLOTS];
   logic                wr_en;
   logic [SLOT_W-1:0]   wr_slot;
   logic [CODE_W-1:0]   wr_code;

   logic                eng_start;
   logic                eng_busy;
   logic                eng_done;
   logic [DIGITS*4-1:0] eng_bcd;
   logic                eng_ovf;
   logic [3:0]          cur_digit;

   bin2bcd_seq #(
      .SCORE_W (SCORE_W),
      .DIGITS  (DIGITS)
   ) u_bin2bcd (
      .clk_i   (Clk),
      .rst_ni  (Reset_n),
      .start_i (eng_start),
      .bin_i   (req_score),
      .busy_o  (eng_busy),
      .done_o  (eng_done),
      .bcd_o   (eng_bcd),
      .ovf_o   (eng_ovf)
   );

   // Pick the digit for the current write position, most significant first.
   // An overflowed score saturates every position to nine.
   always_comb begin
      cur_digit = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == SLOT_W'(DIGITS - 1 - k)) begin
            cur_digit = eng_bcd[k*4 +: 4];
         end
      end
      if (eng_ovf) begin
         cur_digit = 4'd9;
      end
   end

   // Request sequencer: accept, convert, then stream one buffer write per
   // cycle. The converter latches the score itself on the acceptance edge.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_d    = base_q;
      ovf_d     = ovf_q;
`ifdef SCORE_TEXT_LZ_BLANK_EN
      lz_d      = lz_q;
`endif
      eng_start = 1'b0;
      wr_en     = 1'b0;
      wr_slot   = '0;
      wr_code   = CODE_W'(CODE_BLANK);
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               ovf_d = 1'b0;
               idx_d = '0;
               if (req_clear) begin
                  state_d = ST_CLEAR;
               end else begin
                  base_d    = req_base;
                  eng_start = 1'b1;
`ifdef SCORE_TEXT_LZ_BLANK_EN
                  lz_d      = 1'b1;
`endif
                  state_d   = ST_CONVERT;
               end
            end
         end
         ST_CONVERT: begin
            if (eng_done) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wr_en   = 1'b1;
            wr_slot = base_q + idx_q;
            ovf_d   = eng_ovf;
`ifdef SCORE_TEXT_LZ_BLANK_EN
            if (lz_q && (cur_digit == 4'd0) && (idx_q != LAST_DIG)) begin
               wr_code = CODE_W'(CODE_BLANK);
            end else begin
               wr_code = CODE_W'(digit_code(cur_digit));
               lz_d    = 1'b0;
            end
`else
            wr_code = CODE_W'(digit_code(cur_digit));
`endif
            if (idx_q == LAST_DIG) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + SLOT_W'(1);
            end
         end
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_slot = idx_q;
            wr_code = CODE_W'(CODE_BLANK);
            if (idx_q == LAST_SLOT) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + SLOT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         ovf_q   <= 1'b0;
`ifdef SCORE_TEXT_LZ_BLANK_EN
         lz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         ovf_q   <= ovf_d;
`ifdef SCORE_TEXT_LZ_BLANK_EN
         lz_q    <= lz_d;
`endif
      end
   end

   // Character buffer: one write port from the sequencer, reset to blank.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int s = 0; s < SLOTS; s++) begin
            buf_q[s] <= CODE_W'(CODE_BLANK);
         end
      end else if (wr_en) begin
         buf_q[wr_slot] <= wr_code;
      end
   end

   // The converter only runs while the sequencer is converting, so folding
   // its busy in keeps busy truthful without changing its timing.
   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE) || eng_busy;
   assign done      = (state_q == ST_DONE);
   assign ovf       = ovf_q;
   assign rd_code   = buf_q[rd_slot];

endmodule

// File: tb/tb_score_text_writer.sv
// Self-checking bench for score_text_writer, built with a 17-bit score so
// that overflow above 99999 is reachable.
module tb_score_text_writer;

   localparam int SW     = 17;
   localparam int SLOTS  = 8;
   localparam int DIGITS = 5;
   localparam int CW     = 8;
   localparam int MAXVAL = 99999;

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            req_valid;
   logic            req_ready;
   logic            req_clear;
   logic [SW-1:0]   req_score;
   logic [2:0]      req_base;
   logic            busy;
   logic            done;
   logic            ovf;
   logic [2:0]      rd_slot;
   logic [CW-1:0]   rd_code;

   typedef struct {
      bit          clr;
      int unsigned score;
      int          base;
   } vec_t;

   typedef struct {
      int lat;
      bit ovf;
   } exp_t;

   exp_t        sbq [$];
   logic [7:0]  model [SLOTS];
   vec_t        vecs [10];
   int          total = 0;
   int          bad   = 0;

   // 50 MHz system clock.
   always #10 Clk = ~Clk;

   score_text_writer #(
      .SLOTS   (SLOTS),
      .DIGITS  (DIGITS),
      .SCORE_W (SW),
      .CODE_W  (CW)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_clear (req_clear),
      .req_score (req_score),
      .req_base  (req_base),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf),
      .rd_slot   (rd_slot),
      .rd_code   (rd_code)
   );

   // Safety net so a stuck design still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected glyph at digit position i (0 = most significant).
   function automatic logic [7:0] expCode(input int unsigned score, input int i);
      int unsigned pw;
      int unsigned d;
      pw = 1;
      for (int j = 0; j < DIGITS - 1 - i; j++) pw = pw * 10;
      if (score > MAXVAL) return 8'h29;
`ifdef SCORE_TEXT_LZ_BLANK_EN
      if ((i != DIGITS - 1) && (score < pw)) return 8'h00;
`endif
      d = (score / pw) % 10;
      return 8'h20 + 8'(d);
   endfunction

   // Record what an accepted request must do to the buffer and to done/ovf.
   task automatic noteAccept(input bit clr, input int unsigned score, input int base);
      exp_t e;
      if (clr) begin
         for (int s = 0; s < SLOTS; s++) model[s] = 8'h00;
         e.lat = SLOTS;
         e.ovf = 1'b0;
      end else begin
         for (int i = 0; i < DIGITS; i++) model[(base + i) % SLOTS] = expCode(score, i);
         e.lat = SW + DIGITS;
         e.ovf = (score > MAXVAL);
      end
      sbq.push_back(e);
   endtask

   task automatic sweepBuffer(input string tag);
      for (int s = 0; s < SLOTS; s++) begin
         rd_slot = 3'(s);
         #1;
         check($sformatf("%s_slot%0d", tag, s), 32'(rd_code), 32'(model[s]));
      end
   endtask

   // Drive one request and return just after its acceptance edge.
   task automatic applyStimulus(input bit clr, input int unsigned score, input int base, input bit hold);
      @(negedge Clk);
      check("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_clear = clr;
      req_score = SW'(score);
      req_base  = 3'(base);
      @(posedge Clk);
      noteAccept(clr, score, base);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   // Wait for done, then compare latency, ovf, buffer and pulse width.
   task automatic checkOutput(input string tag);
      int   k;
      bit   seen;
      exp_t e;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 200) begin
         @(negedge Clk);
         k++;
         if (k == 1) begin
            check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
            check({tag, "_ready_after_accept"}, 32'(req_ready), 32'd0);
         end
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         check({tag, "_done_timeout"}, 32'd0, 32'd1);
         if (sbq.size() > 0) void'(sbq.pop_front());
         return;
      end
      if (sbq.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sbq.pop_front();
      check({tag, "_latency"}, 32'(k - 1), 32'(e.lat));
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
      sweepBuffer(tag);
      @(negedge Clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_ready_after_done"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int holdDone;

      vecs[0] = '{clr: 1'b0, score: 1234,   base: 0};
      vecs[1] = '{clr: 1'b0, score: 0,      base: 6};
      vecs[2] = '{clr: 1'b0, score: 100000, base: 3};
      vecs[3] = '{clr: 1'b0, score: 5,      base: 2};
      vecs[4] = '{clr: 1'b0, score: 98765,  base: 1};
      vecs[5] = '{clr: 1'b1, score: 0,      base: 0};
      vecs[6] = '{clr: 1'b0, score: 131071, base: 7};
      vecs[7] = '{clr: 1'b0, score: 99999,  base: 4};
      vecs[8] = '{clr: 1'b0, score: 42,     base: 5};
      vecs[9] = '{clr: 1'b0, score: 10203,  base: 0};

      Reset_n   = 1'b0;
      req_valid = 1'b0;
      req_clear = 1'b0;
      req_score = '0;
      req_base  = '0;
      rd_slot   = '0;
      for (int s = 0; s < SLOTS; s++) model[s] = 8'h00;

      // Reset state.
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("reset_ready", 32'(req_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      sweepBuffer("reset");
      Reset_n = 1'b1;

      // Table of requests applied in order; buffer contents accumulate.
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].clr, vecs[v].score, vecs[v].base, 1'b0);
         checkOutput($sformatf("vec%0d", v));
      end

      // Request held through DONE is not taken until the following idle edge.
      applyStimulus(1'b0, 777, 4, 1'b1);
      checkOutput("held_first");
      check("held_not_busy_in_idle", 32'(busy), 32'd0);
      req_score = SW'(888);
      req_base  = 3'd0;
      @(posedge Clk);
      noteAccept(1'b0, 888, 0);
      #1;
      req_valid = 1'b0;
      checkOutput("held_second");

      // Reset pulse at edge T+10 of a conversion aborts without done.
      applyStimulus(1'b0, 54321, 2, 1'b1);
      holdDone = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         if (done !== 1'b0) holdDone++;
      end
      Reset_n = 1'b0;
      #1;
      sbq.delete();
      for (int s = 0; s < SLOTS; s++) model[s] = 8'h00;
      check("abort_no_done_before", 32'(holdDone), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      sweepBuffer("abort");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      noteAccept(1'b0, 54321, 2);
      #1;
      req_valid = 1'b0;
      checkOutput("after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
